// File: rtl/pm_clk_reset_seq.sv
// Purpose : debounces the PLL lock, sequences the core reset and makes the fractional 4 MHz clk_ce.
// Latency : pll_locked -> seq_state change 3 clk (2-flop synchroniser + registered state).
//           Lock loss reaches core_reset/clk_ce on that same registered edge.
// Backpr. : none; free-running sequencer with no handshake and no stall input.
// Ports   : clk, rst_n (async active-low), pll_locked (async), soft_reset, clr_lost (sync pulses)
//           -> core_reset, clk_ce, seq_state[1:0] (0 WAIT_LOCK, 1 HOLD, 2 RUN), lost_lock (sticky).
module pm_clk_reset_seq #(
  parameter int CE_INC      = 43,
  parameter int CE_MOD      = 270,
  parameter int ACC_W       = 9,
  parameter int LOCK_STABLE = 1024,
  parameter int RESET_HOLD  = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       soft_reset,
  input  logic       clr_lost,
  output logic       core_reset,
  output logic       clk_ce,
  output logic [1:0] seq_state,
  output logic       lost_lock
);

  // Counters only need to reach limit-1; the transition fires on that value.
  localparam int LOCK_W = (LOCK_STABLE > 1) ? $clog2(LOCK_STABLE) : 1;
  localparam int HOLD_W = (RESET_HOLD  > 1) ? $clog2(RESET_HOLD)  : 1;

  localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_STABLE - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD - 1);
  localparam logic [ACC_W-1:0]  INC_W     = ACC_W'(CE_INC);
  localparam logic [ACC_W-1:0]  MOD_W     = ACC_W'(CE_MOD);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    RUN       = 2'd2
  } state_t;

  state_t              state;
  logic                sync_q1;
  logic                lk;
  logic [LOCK_W-1:0]   lock_cnt;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [ACC_W-1:0]    acc;
  logic [ACC_W-1:0]    acc_sum;
  logic                ce_wrap;

  // ACC_W is sized so acc + CE_INC never overflows before the modulus compare.
  assign acc_sum   = acc + INC_W;
  assign ce_wrap   = (acc_sum >= MOD_W);
  assign seq_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= WAIT_LOCK;
      sync_q1    <= 1'b0;
      lk         <= 1'b0;
      lock_cnt   <= '0;
      hold_cnt   <= '0;
      acc        <= '0;
      core_reset <= 1'b1;
      clk_ce     <= 1'b0;
      lost_lock  <= 1'b0;
    end else begin
      sync_q1 <= pll_locked;
      lk      <= sync_q1;

      // Clear first; a lock-loss set later in this block overrides it.
      if (clr_lost) begin
        lost_lock <= 1'b0;
      end

      case (state)
        WAIT_LOCK: begin
          core_reset <= 1'b1;
          clk_ce     <= 1'b0;
          acc        <= '0;
          if (!lk) begin
            lock_cnt <= '0;
          end else if (lock_cnt == LOCK_LAST) begin
            // Counter parks at LOCK_LAST; it is cleared again on any lock loss.
            state    <= HOLD;
            hold_cnt <= '0;
          end else begin
            lock_cnt <= lock_cnt + LOCK_W'(1);
          end
        end

        default: begin // HOLD and RUN
          if (!lk) begin
            // Lock loss beats soft_reset and the HOLD->RUN release.
            state      <= WAIT_LOCK;
            core_reset <= 1'b1;
            clk_ce     <= 1'b0;
            acc        <= '0;
            lock_cnt   <= '0;
            lost_lock  <= 1'b1;
          end else begin
            if (ce_wrap) begin
              acc    <= acc_sum - MOD_W;
              clk_ce <= 1'b1;
            end else begin
              acc    <= acc_sum;
              clk_ce <= 1'b0;
            end

            if (soft_reset) begin
              // Enable phase is kept so the core sees an unbroken pulse train.
              state      <= HOLD;
              hold_cnt   <= '0;
              core_reset <= 1'b1;
            end else if (state == HOLD && clk_ce) begin
              // clk_ce here is the registered pulse the core sees this cycle.
              if (hold_cnt == HOLD_LAST) begin
                state      <= RUN;
                core_reset <= 1'b0;
              end else begin
                hold_cnt <= hold_cnt + HOLD_W'(1);
              end
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pm_clk_reset_seq.sv
// Directed bench for pm_clk_reset_seq: power-up sequencing, 43/270 enable rate,
// soft reset, lock loss/glitch handling and asynchronous reset mid-HOLD.
module tb_pm_clk_reset_seq;

  logic       clk;
  logic       rst_n;
  logic       pll_locked;
  logic       soft_reset;
  logic       clr_lost;
  logic       core_reset;
  logic       clk_ce;
  logic [1:0] seq_state;
  logic       lost_lock;

  pm_clk_reset_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pll_locked (pll_locked),
    .soft_reset (soft_reset),
    .clr_lost   (clr_lost),
    .core_reset (core_reset),
    .clk_ce     (clk_ce),
    .seq_state  (seq_state),
    .lost_lock  (lost_lock)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_cmp      = 0;
  int   n_err      = 0;
  int   cyc        = 0;
  int   last_pulse = -1;
  int   bad_gap    = 0;
  int   pulses     = 0;
  int   adjacent   = 0;
  int   wait_bad   = 0;
  logic prev_ce    = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample 1 time unit after the edge; tracks pulse spacing.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (clk_ce === 1'b1) begin
      if (last_pulse >= 0 && ((cyc - last_pulse) < 6 || (cyc - last_pulse) > 7)) bad_gap++;
      if (prev_ce === 1'b1) adjacent++;
      last_pulse = cyc;
      pulses++;
    end
    prev_ce = clk_ce;
    if (seq_state === 2'd0 && (core_reset !== 1'b1 || clk_ce !== 1'b0)) wait_bad++;
  endtask

  task automatic track_clear();
    last_pulse = -1;
    bad_gap    = 0;
    pulses     = 0;
    adjacent   = 0;
  endtask

  task automatic wait_state(input logic [1:0] tgt, input int max, output int n);
    n = 0;
    while (seq_state !== tgt && n < max) begin
      tick();
      n++;
    end
  endtask

  // Walks HOLD until it exits; counts enables and cycles where core_reset was low.
  task automatic hold_phase(output int n, output int p, output int rst_bad, output logic last_ce);
    n = 0; p = 0; rst_bad = 0; last_ce = 1'b0;
    while (seq_state === 2'd1 && n < 2000) begin
      if (clk_ce === 1'b1) p++;
      if (core_reset !== 1'b1) rst_bad++;
      last_ce = clk_ce;
      tick();
      n++;
    end
  endtask

  initial begin
    int   n, p, rb;
    logic lc;

    // ---- power-up ----
    rst_n = 1'b0; pll_locked = 1'b1; soft_reset = 1'b0; clr_lost = 1'b0;
    repeat (5) tick();
    chk("rst_core_reset", core_reset, 1);
    chk("rst_clk_ce",     clk_ce,     0);
    chk("rst_seq_state",  seq_state,  0);
    chk("rst_lost_lock",  lost_lock,  0);

    rst_n = 1'b1;
    wait_state(2'd1, 3000, n);
    chk("pwr_wait_cycles", n, 1026);       // 2 sync + 1024 qualified
    track_clear();
    hold_phase(n, p, rb, lc);
    chk("pwr_hold_cycles",  n,  403);      // 64th pulse at update 402 (43*402 >= 64*270)
    chk("pwr_hold_pulses",  p,  64);
    chk("pwr_hold_rst",     rb, 0);
    chk("pwr_last_ce",      lc, 1);
    chk("pwr_run_state",    seq_state,  2);
    chk("pwr_run_reset",    core_reset, 0);

    // ---- rate check in RUN ----
    track_clear();
    repeat (27000) tick();
    chk("rate_pulses",   pulses,   4300);
    chk("rate_bad_gap",  bad_gap,  0);
    chk("rate_adjacent", adjacent, 0);
    chk("rate_reset",    core_reset, 0);

    // ---- soft reset in RUN; gap tracking carries straight on ----
    soft_reset = 1'b1;
    tick();
    soft_reset = 1'b0;
    chk("soft_core_reset", core_reset, 1);
    chk("soft_seq_state",  seq_state,  1);
    hold_phase(n, p, rb, lc);
    chk("soft_hold_pulses", p, 64);
    chk("soft_hold_rst",    rb, 0);
    chk("soft_run_state",   seq_state, 2);
    repeat (20) tick();
    chk("soft_gap_continuous", bad_gap, 0);

    // ---- loss of lock in RUN (10 cycles low) ----
    pll_locked = 1'b0;
    tick(); tick();
    chk("loss_latency_state", seq_state, 2);
    clr_lost = 1'b1;                        // collides with the set: set must win
    tick();
    clr_lost = 1'b0;
    chk("loss_core_reset", core_reset, 1);
    chk("loss_clk_ce",     clk_ce,     0);
    chk("loss_seq_state",  seq_state,  0);
    chk("loss_lost_lock",  lost_lock,  1);
    clr_lost = 1'b1;
    tick();
    clr_lost = 1'b0;
    chk("clr_lost_lock", lost_lock, 0);
    repeat (6) tick();

    // ---- relock with a soft_reset in WAIT and a 1-cycle glitch at count 500 ----
    pll_locked = 1'b1;
    repeat (100) tick();
    soft_reset = 1'b1;
    tick();
    soft_reset = 1'b0;
    repeat (401) tick();
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    wait_state(2'd1, 3000, n);
    chk("glitch_wait_cycles", n, 1026);     // HOLD at 1529 cycles after relock
    chk("glitch_lost_lock",   lost_lock, 0);
    hold_phase(n, p, rb, lc);
    chk("relock_hold_cycles", n, 403);
    chk("relock_hold_pulses", p, 64);
    chk("relock_run_state",   seq_state, 2);

    // ---- async reset mid-HOLD while clk_ce is high ----
    soft_reset = 1'b1;
    tick();
    soft_reset = 1'b0;
    n = 0;
    while (clk_ce !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("arst_pre_ce",    clk_ce,    1);
    chk("arst_pre_state", seq_state, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_core_reset", core_reset, 1);
    chk("arst_clk_ce",     clk_ce,     0);
    chk("arst_seq_state",  seq_state,  0);
    chk("arst_lost_lock",  lost_lock,  0);
    tick(); tick();
    rst_n = 1'b1;
    wait_state(2'd1, 3000, n);
    chk("arst_wait_cycles", n, 1026);       // lock counter and synchroniser were cleared
    hold_phase(n, p, rb, lc);
    chk("arst_hold_cycles", n, 403);        // accumulator and hold counter were cleared
    chk("arst_hold_pulses", p, 64);

    chk("wait_outputs_quiet", wait_bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pm_clk_reset_seq.md
Name: pm_clk_reset_seq

Overview:
- Sits directly downstream of the system PLL (25.116279 MHz = 1080/43 MHz output).
- Consumes the PLL output clock and its asynchronous `locked` flag.
- Produces a debounced, synchronously-released core reset and a fractional clock-enable that pulses at the Pokemon Mini 4 MHz system rate (exact ratio 43/270).
- Drives the CPU/peripheral core, which runs on `clk` qualified by `clk_ce`.

Parameters:
- CE_INC, 43, phase-accumulator increment per clk cycle.
- CE_MOD, 270, phase-accumulator modulus; pulse rate = clk × CE_INC / CE_MOD. Requires CE_INC < CE_MOD.
- ACC_W, 9, accumulator width; must satisfy 2^ACC_W > CE_MOD + CE_INC.
- LOCK_STABLE, 1024, consecutive synchronised-locked cycles required before leaving WAIT_LOCK.
- RESET_HOLD, 64, number of clk_ce pulses for which core_reset is held after lock is qualified.

Ports:
- clk  in  1  PLL output clock (outclk_0); the only clock.
- rst_n  in  1  asynchronous active-low reset.
- pll_locked  in  1  PLL locked flag; asynchronous to clk.
- soft_reset  in  1  synchronous one-cycle request to re-run the reset hold (e.g. from OSD).
- clr_lost  in  1  synchronous; clears lost_lock.
- core_reset  out  1  active-high reset to the core; asserted asynchronously, released synchronously.
- clk_ce  out  1  single-cycle clock-enable pulse at the 4 MHz rate.
- seq_state  out  2  state encoding: 0 WAIT_LOCK, 1 HOLD, 2 RUN.
- lost_lock  out  1  sticky flag; lock dropped while in HOLD or RUN.

Behaviour:
- Reset: rst_n low asynchronously forces:
  - core_reset=1, clk_ce=0, seq_state=0, lost_lock=0;
  - accumulator=0, lock counter=0, hold counter=0, both synchroniser flops=0.
- pll_locked passes through a 2-flop synchroniser; `lk` below is the synchronised value (2-cycle latency).
- WAIT_LOCK:
  - core_reset=1; clk_ce=0; accumulator held at 0.
  - Lock counter increments while lk=1 and clears to 0 whenever lk=0.
  - When the counter reaches LOCK_STABLE-1 with lk=1, go to HOLD next cycle and clear the hold counter.
- HOLD:
  - core_reset=1; accumulator runs and clk_ce pulses, so the core's synchronous resets see enables.
  - The hold counter increments on each clk_ce pulse.
  - The cycle after the RESET_HOLD-th pulse, go to RUN; core_reset goes to 0 on that registered transition.
- RUN: core_reset=0; clk_ce continues.
- Accumulator rule, every clk in HOLD or RUN:
  - sum = acc + CE_INC, computed at ACC_W width.
  - If sum >= CE_MOD: acc <= sum − CE_MOD and clk_ce <= 1.
  - Otherwise: acc <= sum and clk_ce <= 0.
  - clk_ce is registered. Exactly 43 pulses per 270 clk cycles; pulses are never adjacent (gap of 6 or 7 cycles).
- Loss of lock: lk=0 in HOLD or RUN →
  - next cycle: WAIT_LOCK, core_reset=1, clk_ce=0, accumulator cleared, lost_lock set.
  - Loss of lock takes priority over soft_reset and over the HOLD→RUN transition in the same cycle.
- soft_reset=1:
  - In RUN or HOLD with lk=1: go to HOLD, hold counter cleared, core_reset=1 next cycle; the accumulator is not cleared.
  - In WAIT_LOCK: ignored.
- clr_lost clears lost_lock. If set and clear occur in the same cycle, set wins.
- core_reset is driven only from a register; no combinational path from any input to any output.
- Counter widths: sized by $clog2 of their limits. The lock counter saturates and never wraps.

Test Plan:
- Power-up: rst_n low 5 cycles, then high, with pll_locked=1 from the start → core_reset stays 1 and clk_ce=0 until WAIT_LOCK exits (2 sync + 1024 cycles). Then exactly 64 clk_ce pulses occur, and core_reset falls one cycle after the 64th pulse; seq_state goes 0→1→2.
- Rate check: in RUN, count over 27000 clk cycles → exactly 4300 clk_ce pulses; every inter-pulse gap is 6 or 7 cycles, and no two consecutive cycles both have clk_ce=1.
- Lock glitch during qualification: pll_locked drops for 1 cycle at lock-count 500 → counter restarts; HOLD is entered 1024 cycles after the glitch clears; lost_lock stays 0.
- Loss of lock in RUN: drop pll_locked for 10 cycles → 3 cycles later core_reset=1, clk_ce=0, seq_state=0, lost_lock=1. On relock, the full sequence repeats; clr_lost pulse → lost_lock=0.
- Soft reset in RUN: pulse soft_reset → core_reset=1 next cycle, seq_state=1; release follows after 64 further clk_ce pulses; pulse spacing stays continuous across the event.
- Async reset mid-HOLD: drive rst_n low between clock edges → core_reset=1 and clk_ce=0 immediately (before the next edge), all counters at 0, seq_state=0.
